// File: rtl/instruction_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch stage: opcode field, NOP/HALT encodings, FSM states.
// The optional HALT_DETECT_EN build uses is_halt() to spot the HALT opcode.
package instruction_fetch_unit_pkg;

    localparam int          OPC_HI      = 31;
    localparam int          OPC_LO      = 26;
    localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;
    localparam logic [5:0]  HALT_OP_DEF = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [31:0] ins, input logic [5:0] op);
        return ins[OPC_HI:OPC_LO] == op;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: control/load inputs from the pipeline side, instruction outputs to decode.
interface instruction_fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            load_en;
    logic [PC_W-1:0] load_addr;
    logic [31:0]     load_data;
    logic [31:0]     ins;
    logic [PC_W-1:0] pc_out;
    logic            ins_valid;
    logic            halted;

    modport master (
        output stall, redirect, redirect_pc, load_en, load_addr, load_data,
        input  ins, pc_out, ins_valid, halted
    );

    modport slave (
        input  stall, redirect, redirect_pc, load_en, load_addr, load_data,
        output ins, pc_out, ins_valid, halted
    );
endinterface

// File: rtl/instruction_fetch_unit_imem_ram.sv
// Instruction memory: async read, sync write, contents never reset.
// Async read means a same-edge write is not visible to the fetch on that edge.
module instruction_fetch_unit_imem_ram #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 256
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [PC_W-1:0] i_waddr,
    input  logic [31:0]     i_wdata,
    input  logic [PC_W-1:0] i_raddr,
    output logic [31:0]     o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, instruction memory, registered ins/pc_out/ins_valid with stall and redirect.
// Optional macro HALT_DETECT_EN builds the sticky HALTED state and the halted output.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          PC_W       = 8,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INS    = NOP_INS_DEF,
    parameter logic [5:0]  HALT_OP    = HALT_OP_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.slave   fif
);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e    r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_pc_out, w_pc_out_nxt;
    logic [31:0]     r_ins, w_ins_nxt;
    logic            r_ins_valid, w_ins_valid_nxt;
    logic [31:0]     w_rdata;

    instruction_fetch_unit_imem_ram #(
        .PC_W  (PC_W),
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .i_clk   (clk),
        .i_we    (fif.load_en),
        .i_waddr (fif.load_addr),
        .i_wdata (fif.load_data),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_pc_out    <= '0;
            r_ins       <= NOP_INS;
            r_ins_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_ins       <= w_ins_nxt;
            r_ins_valid <= w_ins_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pc_out_nxt    = r_pc_out;
        w_ins_nxt       = r_ins;
        w_ins_valid_nxt = r_ins_valid;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // redirect beats stall: the in-flight word is squashed into a single bubble
                if (fif.redirect) begin
                    w_pc_nxt        = fif.redirect_pc;
                    w_ins_nxt       = NOP_INS;
                    w_ins_valid_nxt = 1'b0;
                end else if (!fif.stall) begin
                    w_ins_nxt       = w_rdata;
                    w_pc_out_nxt    = r_pc;
                    w_ins_valid_nxt = 1'b1;
                    w_pc_nxt        = r_pc + PC_ONE;
`ifdef HALT_DETECT_EN
                    if (is_halt(w_rdata, HALT_OP)) begin
                        w_state_nxt = ST_HALTED;
                        w_pc_nxt    = r_pc;
                    end
`endif
                end
            end
`ifdef HALT_DETECT_EN
            ST_HALTED: begin
                w_ins_nxt       = NOP_INS;
                w_ins_valid_nxt = 1'b0;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef HALT_DETECT_EN
    // halted rises with the first NOP after the HALT word, not with the state change
    logic r_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_halted <= 1'b0;
        else       r_halted <= (r_state == ST_HALTED);
    end

    assign fif.halted = r_halted;
`else
    logic w_unused_halt_op;
    assign w_unused_halt_op = ^HALT_OP;
    assign fif.halted       = 1'b0;
`endif

    assign fif.ins       = r_ins;
    assign fif.pc_out    = r_pc_out;
    assign fif.ins_valid = r_ins_valid;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed steps push expected outputs,
// a monitor pops and compares after each clock edge and after every async reset.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] M0  = 32'h0022_1800;
    localparam logic [31:0] M1  = 32'h5081_0000;
    localparam logic [31:0] M2  = 32'h10A1_2000;
    localparam logic [31:0] MH  = 32'hFC00_0000;
    localparam logic [31:0] M40 = 32'hDEAD_0040;
    localparam logic [31:0] MFF = 32'hAB00_00FF;
    localparam logic [31:0] MN1 = 32'h7777_0001;

    typedef struct {
        int          cyc;
        logic [31:0] ins;
        logic [7:0]  pc;
        logic        v;
        logic        h;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    instruction_fetch_unit_if #(.PC_W(8)) fif ();

    instruction_fetch_unit #(
        .PC_W       (8),
        .IMEM_DEPTH (256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.nm, e.cyc, cyc);
            end else if ({fif.ins, fif.pc_out, fif.ins_valid, fif.halted} !== {e.ins, e.pc, e.v, e.h}) begin
                errors++;
                $display("FAIL %s: got ins=%h pc=%h v=%b h=%b, expected ins=%h pc=%h v=%b h=%b",
                         e.nm, fif.ins, fif.pc_out, fif.ins_valid, fif.halted, e.ins, e.pc, e.v, e.h);
            end
        end
    end

    // async reset must clear outputs without waiting for a clock edge
    always @(posedge reset) begin
        #1;
        checks++;
        if ({fif.ins, fif.pc_out, fif.ins_valid, fif.halted} !== {NOP, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got ins=%h pc=%h v=%b h=%b, expected ins=%h pc=00 v=0 h=0",
                     fif.ins, fif.pc_out, fif.ins_valid, fif.halted, NOP);
        end
    end

    // inputs set by the caller apply to the next edge; expectation is for after that edge
    task automatic step(input string nm, input logic [31:0] ei, input logic [7:0] ep,
                        input logic ev, input logic eh);
        exp_t e;
        e.cyc = cyc + 1;
        e.ins = ei;
        e.pc  = ep;
        e.v   = ev;
        e.h   = eh;
        e.nm  = nm;
        sb.push_back(e);
        @(negedge clk);
        fif.stall    = 1'b0;
        fif.redirect = 1'b0;
        fif.load_en  = 1'b0;
    endtask

    task automatic ld(input logic [7:0] a, input logic [31:0] d);
        fif.load_en   = 1'b1;
        fif.load_addr = a;
        fif.load_data = d;
        step("load_in_reset", NOP, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset           = 1'b0;
        fif.stall       = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 8'h00;
        fif.load_en     = 1'b0;
        fif.load_addr   = 8'h00;
        fif.load_data   = 32'h0;
        #1 reset = 1'b1;
        @(negedge clk);

        ld(8'h00, M0); ld(8'h01, M1); ld(8'h02, M2); ld(8'h03, MH);
        ld(8'h40, M40); ld(8'hFF, MFF);

        reset = 1'b0;
        step("idle", NOP, 8'h00, 1'b0, 1'b0);
        step("fetch0", M0, 8'h00, 1'b1, 1'b0);
        step("fetch1", M1, 8'h01, 1'b1, 1'b0);
        fif.stall = 1'b1; step("stall_a", M1, 8'h01, 1'b1, 1'b0);
        fif.stall = 1'b1; step("stall_b", M1, 8'h01, 1'b1, 1'b0);
        step("fetch2", M2, 8'h02, 1'b1, 1'b0);
        fif.stall = 1'b1; fif.redirect = 1'b1; fif.redirect_pc = 8'h40;
        step("redir_bubble", NOP, 8'h02, 1'b0, 1'b0);
        step("redir_target", M40, 8'h40, 1'b1, 1'b0);
        fif.redirect = 1'b1; fif.redirect_pc = 8'hFF;
        step("redir_ff", NOP, 8'h40, 1'b0, 1'b0);
        step("fetch_ff", MFF, 8'hFF, 1'b1, 1'b0);
        step("wrap_0", M0, 8'h00, 1'b1, 1'b0);
        fif.load_en = 1'b1; fif.load_addr = 8'h01; fif.load_data = MN1;
        step("rd_before_wr", M1, 8'h01, 1'b1, 1'b0);
        fif.redirect = 1'b1; fif.redirect_pc = 8'h01;
        step("redir_1", NOP, 8'h01, 1'b0, 1'b0);
        step("new_word", MN1, 8'h01, 1'b1, 1'b0);
        step("fetch2b", M2, 8'h02, 1'b1, 1'b0);
        step("halt_word", MH, 8'h03, 1'b1, 1'b0);
`ifdef HALT_DETECT_EN
        fif.stall = 1'b1;
        step("halted", NOP, 8'h03, 1'b0, 1'b1);
        fif.redirect = 1'b1; fif.redirect_pc = 8'h40;
        step("halt_redir_ign", NOP, 8'h03, 1'b0, 1'b1);
        step("halt_sticky", NOP, 8'h03, 1'b0, 1'b1);
`else
        fif.stall = 1'b1;
        step("nohalt_stall", MH, 8'h03, 1'b1, 1'b0);
        fif.redirect = 1'b1; fif.redirect_pc = 8'h40;
        step("nohalt_redir", NOP, 8'h03, 1'b0, 1'b0);
`endif
        reset = 1'b1;
        step("rst_hold", NOP, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step("idle2", NOP, 8'h00, 1'b0, 1'b0);
        step("restart0", M0, 8'h00, 1'b1, 1'b0);
        step("restart1", MN1, 8'h01, 1'b1, 1'b0);
        #2 reset = 1'b1;
        step("rst_mid_hold", NOP, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step("idle3", NOP, 8'h00, 1'b0, 1'b0);
        step("restart_again", M0, 8'h00, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
